lfsr_gal: RTL

Parametrised Galois LFSR. Successor to the fixed 8-bit, poly-0x95 generator.

- Generalised in width, polynomial, seed and bits-per-clock (STEPS).
- Adds synchronous seed load with zero-lockup protection.
- Adds a built-in period meter that verifies maximal-length operation on silicon.
- Sits beside the test/entropy logic; its state and output bits feed the scrambler and the TT output mux.

---
 rtl/lfsr_pkg.sv | 54 +++++
 rtl/lfsr_gal_step.sv | 19 +
 rtl/lfsr_gal.sv | 103 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the Galois LFSR family: default 8-bit pair,
// recommended primitive toggle masks (right-shift convention) and period helper.
package lfsr_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  localparam logic [7:0] POLY_8 = 8'h95;
  localparam logic [7:0] SEED_8 = 8'h06;

  typedef logic [MAX_WIDTH-1:0] mask_t;

  // Bit k of a mask toggles state bit k when the shifted-out bit is 1;
  // the top bit is always set so the map is invertible.
  function automatic mask_t primitive_mask(input int width);
    case (width)
      4:       primitive_mask = 32'h0000_0009;
      5:       primitive_mask = 32'h0000_0012;
      6:       primitive_mask = 32'h0000_0021;
      7:       primitive_mask = 32'h0000_0041;
      8:       primitive_mask = 32'h0000_0095;
      9:       primitive_mask = 32'h0000_0108;
      10:      primitive_mask = 32'h0000_0204;
      11:      primitive_mask = 32'h0000_0402;
      12:      primitive_mask = 32'h0000_0CA0;
      13:      primitive_mask = 32'h0000_1B00;
      14:      primitive_mask = 32'h0000_3500;
      15:      primitive_mask = 32'h0000_4001;
      16:      primitive_mask = 32'h0000_B400;
      17:      primitive_mask = 32'h0001_0004;
      18:      primitive_mask = 32'h0002_0040;
      19:      primitive_mask = 32'h0007_1000;
      20:      primitive_mask = 32'h0008_0004;
      21:      primitive_mask = 32'h0010_0002;
      22:      primitive_mask = 32'h0020_0001;
      23:      primitive_mask = 32'h0040_0010;
      24:      primitive_mask = 32'h0080_0043;
      25:      primitive_mask = 32'h0100_0004;
      26:      primitive_mask = 32'h0388_0000;
      27:      primitive_mask = 32'h0720_0000;
      28:      primitive_mask = 32'h0800_0004;
      29:      primitive_mask = 32'h1000_0002;
      30:      primitive_mask = 32'h3280_0000;
      31:      primitive_mask = 32'h4000_0004;
      32:      primitive_mask = 32'hE000_0200;
      default: primitive_mask = '0;
    endcase
  endfunction

  function automatic longint unsigned max_period(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/lfsr_gal_step.sv
// One combinational Galois substep: shift right, toggle POLY when the
// outgoing bit is 1, and flag an all-ones successor.
module lfsr_gal_step
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = POLY_8
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_next,
  output logic             out_bit,
  output logic             is_ones
);

  assign out_bit = s[0];
  assign s_next  = (s >> 1) ^ (s[0] ? POLY : '0);
  assign is_ones = &s_next;

endmodule

// File: rtl/lfsr_gal.sv
// Parametrised Galois LFSR advancing STEPS substeps per enabled clock, with
// zero-safe seed load and an on-chip period meter keyed on the all-ones state.
module lfsr_gal
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = POLY_8,
  parameter logic [WIDTH-1:0] SEED  = SEED_8,
  parameter int               STEPS = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LFSR_EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] LFSR_STATE,
  output logic [STEPS-1:0] LFSR_BITS,
  output logic             LFSR_PERIOD,
  output logic [WIDTH:0]   PERIOD_LEN,
  output logic             PERIOD_VALID
);

  localparam int            CW       = WIDTH + 1;
  localparam logic [CW-1:0] STEP_INC = CW'(STEPS);

  logic [WIDTH-1:0] chain [STEPS+1];
  logic [STEPS-1:0] sub_bits;
  logic [STEPS-1:0] sub_hit;
  logic             any_hit;
  logic [CW-1:0]    hit_idx;
  logic [CW-1:0]    hit_off;
  logic [CW-1:0]    cnt_rest;
  logic [CW-1:0]    cnt;
  logic             armed;

  assign chain[0] = LFSR_STATE;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_gal_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .s       (chain[g]),
      .s_next  (chain[g+1]),
      .out_bit (sub_bits[g]),
      .is_ones (sub_hit[g])
    );
  end

  // At most one substep can land on all-ones per clock, so a plain scan suffices.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred when no substep hits.
    hit_idx = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (sub_hit[i]) hit_idx = CW'(i);
    end
  end

  assign any_hit  = |sub_hit;
  assign hit_off  = hit_idx + CW'(1);
  assign cnt_rest = STEP_INC - hit_off;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CW] ? '1 : sum[CW-1:0];
  endfunction

  // Idle clocks freeze everything, including the hit flag, so it keeps tracking the held state.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    if (RESET) begin
      LFSR_STATE   <= SEED;
      LFSR_BITS    <= '0;
      LFSR_PERIOD  <= 1'b0;
      PERIOD_LEN   <= '0;
      PERIOD_VALID <= 1'b0;
      cnt          <= '0;
      armed        <= 1'b0;
    end else if (LOAD) begin
      LFSR_STATE   <= (LOAD_VAL == '0) ? SEED : LOAD_VAL;
      LFSR_PERIOD  <= 1'b0;
      PERIOD_VALID <= 1'b0;
      cnt          <= '0;
      armed        <= 1'b0;
    end else if (LFSR_EN) begin
      LFSR_STATE  <= chain[STEPS];
      LFSR_BITS   <= sub_bits;
      LFSR_PERIOD <= any_hit;
      if (any_hit) begin
        if (armed) begin
          PERIOD_LEN   <= sat_add(cnt, hit_off);
          PERIOD_VALID <= 1'b1;
        end
        armed <= 1'b1;
        cnt   <= cnt_rest;
      end else begin
        cnt <= sat_add(cnt, STEP_INC);
      end
    end
  end

endmodule
